// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b computed LSB first, one bit per clock,
// using a full-subtractor cell with a borrow flip-flop and an IDLE/RUN/DONE FSM.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_bff;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_next;

    // Full-subtractor cell on the current LSBs.
    assign w_x         = r_a_sr[0];
    assign w_y         = r_b_sr[0];
    assign w_d         = w_x ^ w_y ^ r_bff;
    assign w_bout      = (~w_x & w_y) | (~(w_x ^ w_y) & r_bff);
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    assign w_diff_next = {w_d, r_diff_sr[WIDTH-1:1]};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are cleared too, so an aborted op leaves nothing behind.
            r_state   <= IDLE;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_diff    <= '0;
            r_cnt     <= '0;
            r_bff     <= 1'b0;
            r_borrow  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr    <= a;
                        r_b_sr    <= b;
                        r_bff     <= 1'b0;
                        r_cnt     <= '0;
                        r_diff_sr <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_diff_sr <= w_diff_next;
                    r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_bff     <= w_bout;
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Capture the final bit and borrow directly so the result is complete on DONE entry.
                        r_diff   <= w_diff_next;
                        r_borrow <= w_bout;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
endmodule
